// File: rtl/stepper_pkg.sv
// Shared types, coil tables and phase width for stepper_move_ctrl.
// STEPPER_HALF_STEP_EN selects the 8-entry half-step sequence.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int FULL_PHASES = 4;
  localparam int HALF_PHASES = 8;

  // Entry 0 sits in the least significant slot
  localparam logic [FULL_PHASES-1:0][3:0] FULL_TABLE = {
    4'b1001, 4'b0011, 4'b0110, 4'b1100
  };

  localparam logic [HALF_PHASES-1:0][3:0] HALF_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

`ifdef STEPPER_HALF_STEP_EN
  localparam int PHASES = HALF_PHASES;
`else
  localparam int PHASES = FULL_PHASES;
`endif

  typedef logic [$clog2(PHASES)-1:0] phase_t;

  function automatic logic [3:0] coil_of(input phase_t idx);
`ifdef STEPPER_HALF_STEP_EN
    return HALF_TABLE[idx];
`else
    return FULL_TABLE[idx];
`endif
  endfunction

endpackage

// File: rtl/step_tick_detect.sv
// One-cycle rising-edge pulse on a same-domain divided clock.
module step_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic tick_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign tick_o = sig_i & ~sig_q;

endmodule

// File: rtl/stepper_move_ctrl.sv
// Relative-move executor for a 4-coil stepper driven by step_clk ticks.
// Build option STEPPER_HALF_STEP_EN switches to half-step phasing.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int STEPS_W   = 16,
  parameter bit IDLE_HOLD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_clk,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  output logic [3:0]         coil,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
);

  state_t             state_q;
  phase_t             phase_q;
  phase_t             phase_d;
  logic [3:0]         coil_q;
  logic               busy_q;
  logic               done_q;
  logic               dir_q;
  logic [STEPS_W-1:0] left_q;
  logic               tick;

  step_tick_detect u_tick (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (step_clk),
    .tick_o (tick)
  );

  assign phase_d = dir_q ? phase_q + phase_t'(1)
                         : phase_q - phase_t'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      coil_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      left_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_q  <= cmd_dir;
            left_q <= cmd_steps;
            if (cmd_steps == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort beats a coincident tick: no step is taken
          if (abort) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (tick) begin
            phase_q <= phase_d;
            coil_q  <= coil_of(phase_d);
            left_q  <= left_q - STEPS_W'(1);
            if (left_q == STEPS_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (IDLE_HOLD == 1'b0) coil_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign coil       = coil_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: directed moves, random moves, reset mid-move.
module tb_stepper_move_ctrl;

  logic        clk;
  logic        rst;
  logic        step_clk;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic        abort;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;

  stepper_move_ctrl #(.STEPS_W(16), .IDLE_HOLD(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_clk   (step_clk),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .abort      (abort),
    .coil       (coil),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int NPH = 4;
  logic [3:0] tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

  int          vecs = 0;
  int          errs = 0;
  int          pos  = 0;
  bit          mon_en = 0;
  logic [3:0]  exp_coil [$];
  logic [15:0] exp_done [$];
  logic [3:0]  prev_coil;
  logic        done_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every coil change and every done pulse must match the queue head
  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      prev_coil = coil;
      done_prev = done;
    end else begin
      if (coil !== prev_coil) begin
        if (exp_coil.size() == 0) begin
          vecs++; errs++;
          $display("FAIL coil_unexpected: got %b, no step expected", coil);
        end else begin
          chk("coil", {28'd0, coil}, {28'd0, exp_coil.pop_front()});
        end
      end
      prev_coil = coil;
      if (done === 1'b1) begin
        chk("done_width", {31'd0, done_prev}, 32'd0);
        if (exp_done.size() == 0) begin
          vecs++; errs++;
          $display("FAIL done_unexpected: steps_left=%0d, no done expected",
                   steps_left);
        end else begin
          chk("done_left", {16'd0, steps_left},
              {16'd0, exp_done.pop_front()});
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 20);
    chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_move(input bit dir, input int n, input int abort_at,
                         input bit junk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = 16'(n);
    if (n == 0) exp_done.push_back(16'd0);
    @(negedge clk);
    chk("ready_after_accept", {31'd0, cmd_ready}, 32'd0);
    if (n == 0) begin
      cmd_valid = 1'b0;
      chk("zero_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("zero_busy_idle", {31'd0, busy}, 32'd0);
      return;
    end
    if (junk) begin
      cmd_dir   = ~dir;
      cmd_steps = 16'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      step_clk = 1'b1;
      if (k == abort_at) begin
        abort = 1'b1;
        exp_done.push_back(16'(n - k + 1));
      end else begin
        pos = (pos + (dir ? 1 : NPH - 1)) % NPH;
        exp_coil.push_back(tbl[pos]);
        if (k == n) exp_done.push_back(16'd0);
      end
      @(negedge clk);
      step_clk = 1'b0;
      abort    = 1'b0;
      if (k == abort_at) break;
    end
    chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    wait_ready();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ab;
    rst = 1'b1; step_clk = 1'b0; cmd_valid = 1'b0;
    cmd_dir = 1'b0; cmd_steps = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coil", {28'd0, coil}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_left", {16'd0, steps_left}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    do_move(1'b1, 5, 0, 1'b0);
`ifndef STEPPER_HALF_STEP_EN
    chk("t1_coil", {28'd0, coil}, 32'h6);
`endif
    chk("t1_left", {16'd0, steps_left}, 32'd0);

    do_move(1'b0, 3, 0, 1'b0);
`ifndef STEPPER_HALF_STEP_EN
    chk("t2_coil", {28'd0, coil}, 32'h3);
`endif

    do_move(1'b1, 0, 0, 1'b0);
    do_move(1'b1, 10, 4, 1'b0);
    chk("t4_left", {16'd0, steps_left}, 32'd7);
    do_move(1'b0, 6, 0, 1'b1);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);

    repeat (40) begin
      n  = $urandom_range(0, 12);
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
      do_move(1'($urandom_range(0, 1)), n, ab, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a move
    wait_ready();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      step_clk = 1'b1;
      pos = (pos + 1) % NPH;
      exp_coil.push_back(tbl[pos]);
      @(negedge clk);
      step_clk = 1'b0;
    end
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_coil", {28'd0, coil}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_left", {16'd0, steps_left}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pos = 0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("mid_rst_pending", exp_coil.size(), 32'd0);

    do_move(1'b1, 3, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("coil_queue_empty", exp_coil.size(), 32'd0);
    chk("done_queue_empty", exp_done.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
